// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and lane-mask constants for the MIPS core bus adapter.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_t;

  localparam logic [7:0] MASK_BYTE  = 8'h01;
  localparam logic [7:0] MASK_HALF  = 8'h03;
  localparam logic [7:0] MASK_WORD  = 8'h0F;
  localparam logic [7:0] MASK_DWORD = 8'hFF;

  // Unshifted byte-lane mask for an access size.
  function automatic logic [7:0] size_mask(input size_t s);
    case (s)
      SZ_BYTE:  return MASK_BYTE;
      SZ_HALF:  return MASK_HALF;
      SZ_WORD:  return MASK_WORD;
      default:  return MASK_DWORD;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lane_align.sv
// Combinational lane logic: byteenable, store-data replication,
// load-data extraction with sign/zero extension, misalignment detect.
module mips_cpu_lane_align
  import mips_cpu_bus_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int LB    = $clog2(LANES)
) (
  input  logic [1:0]        size,
  input  logic [LB-1:0]     lane,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misaligned
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] left;
  int                sh;

  // Misalignment: the lane offset must be a multiple of the access size.
  always_comb begin
    misaligned = 1'b0;
    case (size_t'(size))
      SZ_HALF:  misaligned = lane[0];
      SZ_WORD:  misaligned = (lane[1:0] != 2'b00);
      SZ_DWORD: misaligned = (DATA_W == 32) ? 1'b1 : (lane != '0);
      default:  misaligned = 1'b0;
    endcase
  end

  // Byteenable and lane-replicated store data.
  always_comb begin
    be = LANES'(size_mask(size_t'(size)) << lane);
    case (size_t'(size))
      SZ_BYTE: wdata_rep = {LANES{wdata[7:0]}};
      SZ_HALF: wdata_rep = {(LANES/2){wdata[15:0]}};
      SZ_WORD: wdata_rep = {(LANES/4){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Load data: move the addressed lane to bit 0, then push the field to
  // the top and shift back down arithmetically or logically to extend.
  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (size_t'(size))
      SZ_BYTE: sh = DATA_W - 8;
      SZ_HALF: sh = DATA_W - 16;
      SZ_WORD: sh = DATA_W - 32;
      default: sh = 0;
    endcase
    left      = shifted << sh;
    rdata_ext = is_signed ? $unsigned($signed(left) >>> sh) : (left >> sh);
  end

endmodule

// File: rtl/mips_cpu_bus_adapter.sv
// Avalon-MM master between the multicycle core and the memory bus.
// Optional feature macro: BUS_TIMEOUT_EN (abort a stalled access after
// TIMEOUT_CYCLES waitrequest-high cycles, reported as err=10).
//
// Handshakes: the core presents core_req with its access fields; the request
// is taken on an edge where core_busy is low (IDLE) and core_req is high, and
// completes with a one-cycle core_done. On the bus, memread/memwrite act as
// valid and !waitrequest as ready: address, data and byteenable are held
// constant until the first edge on which waitrequest is low.
module mips_cpu_bus_adapter
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int LANES = DATA_W / 8,
  localparam int LB    = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [1:0]        core_size,
  input  logic              core_signed,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_busy,
  output logic              core_done,
  output logic [1:0]        core_err,
  output logic [DATA_W-1:0] core_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              memread,
  output logic              memwrite,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] memwritedata,
  output logic [LANES-1:0]  byteenable,
  input  logic [DATA_W-1:0] memreaddata,
  output logic [1:0]        dbg_state
);

  bus_state_t        state;
  logic              lat_we;
  logic              lat_signed;
  logic [1:0]        lat_size;
  logic [LB-1:0]     lat_lane;

  logic [1:0]        sel_size;
  logic [LB-1:0]     sel_lane;
  logic              sel_signed;
  logic [LANES-1:0]  al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              al_misaligned;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  to_cnt;
`endif

  assign dbg_state = state;

  // Lane logic sees the live core fields while idle, the latched ones after.
  always_comb begin
    sel_size   = (state == IDLE) ? core_size               : lat_size;
    sel_lane   = (state == IDLE) ? core_addr[LB-1:0]       : lat_lane;
    sel_signed = (state == IDLE) ? core_signed             : lat_signed;
  end

  mips_cpu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size       (sel_size),
    .lane       (sel_lane),
    .is_signed  (sel_signed),
    .wdata      (core_wdata),
    .rdata      (memreaddata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned)
  );

  // Access FSM with registered bus and core-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      core_busy    <= 1'b0;
      core_done    <= 1'b0;
      core_err     <= ERR_OK;
      core_rdata   <= '0;
      mem_address  <= '0;
      memread      <= 1'b0;
      memwrite     <= 1'b0;
      memwritedata <= '0;
      byteenable   <= '0;
      lat_we       <= 1'b0;
      lat_signed   <= 1'b0;
      lat_size     <= 2'b00;
      lat_lane     <= '0;
`ifdef BUS_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      core_done <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req) begin
            lat_we     <= core_we;
            lat_signed <= core_signed;
            lat_size   <= core_size;
            lat_lane   <= core_addr[LB-1:0];
            core_busy  <= 1'b1;
            if (al_misaligned) begin
              state     <= DONE;
              core_done <= 1'b1;
              core_err  <= ERR_MISALIGN;
            end else begin
              state        <= BUS;
              core_err     <= ERR_OK;
              mem_address  <= {core_addr[ADDR_W-1:LB], {LB{1'b0}}};
              memread      <= !core_we;
              memwrite     <= core_we;
              memwritedata <= al_wdata;
              byteenable   <= al_be;
`ifdef BUS_TIMEOUT_EN
              to_cnt       <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            state     <= DONE;
            core_done <= 1'b1;
            if (!lat_we) core_rdata <= al_rdata;
          end
`ifdef BUS_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            state     <= DONE;
            core_done <= 1'b1;
            core_err  <= ERR_TIMEOUT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state     <= IDLE;
          core_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
